// File: rtl/gmac_tx_arbiter_pkg.sv
// rtl/gmac_tx_arbiter_pkg.sv - shared constants and helpers for the GMAC TX arbiter
package gmac_tx_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int   GMAC_MAX_LEN = 1514;
  localparam logic TUSER_ABORT  = 1'b1;

  // Cyclic index advance; step is always below n.
  function automatic int rr_wrap(input int base, input int step, input int n);
    int v;
    v = base + step;
    if (v >= n) v = v - n;
    return v;
  endfunction

endpackage

// File: rtl/gmac_tx_rr_pick.sv
// rtl/gmac_tx_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module gmac_tx_rr_pick
  import gmac_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PW-1:0]      idx,
  output logic               any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_wrap(int'(ptr), k, NUM_REQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/gmac_tx_arbiter.sv
// rtl/gmac_tx_arbiter.sv - frame-granular round-robin arbiter onto the GMAC TX stream,
// aborting underrun/oversize frames via tuser and draining the rest of the source frame
module gmac_tx_arbiter
  import gmac_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MAX_LEN = GMAC_MAX_LEN,
  parameter int CNT_W   = 16
) (
  input  logic                   I_tx_mac_aclk,
  input  logic                   I_reset_n,
  input  logic                   I_enable,
  input  logic [8*NUM_REQ-1:0]   I_req_tdata,
  input  logic [NUM_REQ-1:0]     I_req_tvalid,
  input  logic [NUM_REQ-1:0]     I_req_tlast,
  output logic [NUM_REQ-1:0]     O_req_tready,
  output logic [7:0]             O_tx_axis_mac_tdata,
  output logic                   O_tx_axis_mac_tvalid,
  output logic                   O_tx_axis_mac_tlast,
  output logic                   O_tx_axis_mac_tuser,
  input  logic                   I_tx_axis_mac_tready,
  output logic [NUM_REQ-1:0]     O_grant,
  output logic                   O_busy,
  output logic                   O_err_underrun,
  output logic                   O_err_oversize,
  output logic [CNT_W-1:0]       O_frame_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_LEN + 1);

  logic [1:0]         state;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      gidx;
  logic [PW-1:0]      ptr;
  logic [BW-1:0]      count;
  logic [CNT_W-1:0]   frame_cnt;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;

  logic [7:0]         req_byte [NUM_REQ];
  logic [7:0]         src_data;
  logic               src_valid;
  logic               src_last;
  logic               at_limit;
  logic [PW-1:0]      next_ptr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
    assign req_byte[i] = I_req_tdata[8*i +: 8];
  end

  gmac_tx_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req    (I_req_tvalid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign src_data  = req_byte[gidx];
  assign src_valid = I_req_tvalid[gidx];
  assign src_last  = I_req_tlast[gidx];
  // Beat MAX_LEN is about to go out without the source's tlast.
  assign at_limit  = (count == BW'(MAX_LEN - 1));
  assign next_ptr  = PW'(rr_wrap(int'(gidx), 1, NUM_REQ));

  always_comb begin
    O_tx_axis_mac_tdata  = 8'h00;
    O_tx_axis_mac_tvalid = 1'b0;
    O_tx_axis_mac_tlast  = 1'b0;
    O_tx_axis_mac_tuser  = 1'b0;
    O_req_tready         = '0;
    O_err_underrun       = 1'b0;
    O_err_oversize       = 1'b0;
    case (state)
      ST_XFER: begin
        O_tx_axis_mac_tvalid = 1'b1;
        if (src_valid) begin
          O_req_tready[gidx]  = I_tx_axis_mac_tready;
          O_tx_axis_mac_tdata = src_data;
          O_tx_axis_mac_tlast = src_last | at_limit;
          O_tx_axis_mac_tuser = at_limit & ~src_last;
          O_err_oversize      = I_tx_axis_mac_tready & at_limit & ~src_last;
        end else begin
          // Underrun: the MAC must not see tvalid drop mid-frame, so close it with an abort beat.
          O_tx_axis_mac_tlast = 1'b1;
          O_tx_axis_mac_tuser = TUSER_ABORT;
          O_err_underrun      = I_tx_axis_mac_tready;
        end
      end
      ST_ABORT: begin
        O_tx_axis_mac_tvalid = 1'b1;
        O_tx_axis_mac_tlast  = 1'b1;
        O_tx_axis_mac_tuser  = TUSER_ABORT;
        O_err_underrun       = I_tx_axis_mac_tready;
      end
      ST_DRAIN: begin
        O_req_tready[gidx] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_tx_mac_aclk) begin
    if (!I_reset_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      gidx      <= '0;
      ptr       <= '0;
      count     <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_enable && pick_any) begin
            grant <= pick_onehot;
            gidx  <= pick_idx;
            count <= '0;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (src_valid) begin
            if (I_tx_axis_mac_tready) begin
              count <= count + 1'b1;
              if (src_last) begin
                frame_cnt <= frame_cnt + 1'b1;
                ptr       <= next_ptr;
                grant     <= '0;
                state     <= ST_IDLE;
              end else if (at_limit) begin
                state <= ST_DRAIN;
              end
            end
          end else begin
            state <= I_tx_axis_mac_tready ? ST_DRAIN : ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (I_tx_axis_mac_tready) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (src_valid && src_last) begin
            ptr   <= next_ptr;
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign O_grant     = grant;
  assign O_busy      = (state != ST_IDLE);
  assign O_frame_cnt = frame_cnt;

endmodule
